mem_addr_checker: RTL

Parametrised address-existence checker with a populated-entry table. Lookup requests use a valid/ready handshake and receive a registered response carrying stored data and a v_err flag. An error is flagged when the address is out of range or the entry is not populated. Sits beside memory-mapped slaves as a legality front-end, and adds error counting and sticky status for SVA-based monitoring.

---
 rtl/mem_addr_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_addr_checker.sv
// Address-existence checker: a populated-bit table with per-entry data, a
// valid/ready lookup port, a registered response and error accounting.
module mem_addr_checker #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_set,
  output logic                 wr_err,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 v_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0]     pop_q, pop_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 v_err_q, v_err_d;
  logic                 wr_err_q, wr_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0]    rd_mem;
  logic                 wr_ok, rd_in_range, same_addr, rd_pop, hit, accept, err_evt;

  assign req_ready  = !rsp_valid_q || rsp_ready;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign v_err      = v_err_q;
  assign wr_err     = wr_err_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

  always_comb begin
    wr_idx      = wr_addr[IDX_W-1:0];
    rd_idx      = req_addr[IDX_W-1:0];
    wr_ok       = wr_en && ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range = {1'b0, req_addr} < DEPTH_L;
    // Write-first bypass: a same-cycle write to the looked-up entry wins.
    same_addr   = wr_ok && (wr_addr == req_addr);
    rd_pop      = same_addr ? wr_set  : pop_q[rd_idx];
    rd_mem      = same_addr ? wr_data : mem_q[rd_idx];
    hit         = rd_in_range && rd_pop;
    accept      = req_valid && req_ready;
    err_evt     = accept && !hit;

    pop_d = pop_q;
    if (wr_ok) pop_d[wr_idx] = wr_set;

    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    v_err_d     = v_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = hit ? rd_mem : '0;
      v_err_d     = !hit;
    end

    wr_err_d = wr_en && !wr_ok;

    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (err_evt) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      v_err_q      <= 1'b0;
      wr_err_q     <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      pop_q        <= pop_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      v_err_q      <= v_err_d;
      wr_err_q     <= wr_err_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Data storage has no reset; the populated bits gate every read.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok && wr_set) mem_q[wr_idx] <= wr_data;
  end

  property p_rsp_hold;
    @(posedge clk) disable iff (reset)
      rsp_valid_q && !rsp_ready |=> $stable({rsp_valid_q, rsp_data_q, v_err_q});
  endproperty
  a_rsp_hold: assert property (p_rsp_hold);

endmodule
